// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl -- data memory readback engine.
// On start it holds the CPU in reset, sweeps a word range of data memory via
// Ext_DataAdr and streams each word out over a valid/ready handshake, one beat
// per word, with a done pulse at the end.
// RD_LATENCY (0..3) is the number of cycles from an address change until
// ReadData is valid.
// Optional feature: define DMEM_DUMP_CHECKSUM_EN to append a final beat that
// carries the modulo-2^32 sum of all dumped words.
module dmem_dump_ctrl #(
  parameter int RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_count,
  input  logic [31:0] ReadData,
  input  logic        out_ready,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_hold,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  // Value of the wait counter on the final ADDR cycle.
  localparam logic [1:0] WaitLast = 2'(RD_LATENCY);

`ifdef DMEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    SEND = 3'd2,
    DONE = 3'd4
  } state_t;
`endif

  state_t      state;
  logic [31:0] baseReg;     // word-aligned start address of the dump
  logic [15:0] countReg;    // number of words in the dump
  logic [15:0] wordIndex;   // index of the word currently addressed
  logic [1:0]  waitCnt;     // cycles spent in the current ADDR visit
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [31:0] sumReg;      // running modulo-2^32 sum of handshaken words
`endif

  logic        handshake;
  logic        lastWord;
  logic [15:0] nextIndex;
  logic [31:0] nextAdr;
  logic [31:0] alignedBase;

  // Handshake, end-of-range and next-address helpers.
  always_comb begin
    handshake   = out_valid && out_ready;
    lastWord    = (wordIndex == (countReg - 16'd1));
    nextIndex   = wordIndex + 16'd1;
    // Address arithmetic is modulo 2^32, so the sweep wraps past 0xFFFFFFFC.
    nextAdr     = baseReg + {14'd0, nextIndex, 2'b00};
    alignedBase = base_adr & ~32'd3;
  end

  // Dump sequencer: state, address sweep and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      baseReg     <= 32'd0;
      countReg    <= 16'd0;
      wordIndex   <= 16'd0;
      waitCnt     <= 2'd0;
`ifdef DMEM_DUMP_CHECKSUM_EN
      sumReg      <= 32'd0;
`endif
      Ext_DataAdr <= 32'd0;
      cpu_hold    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            baseReg   <= alignedBase;
            countReg  <= word_count;
            wordIndex <= 16'd0;
            waitCnt   <= 2'd0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sumReg    <= 32'd0;
`endif
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
            if (word_count == 16'd0) begin
              // Empty dump: no beats, just the completion pulse.
              done  <= 1'b1;
              state <= DONE;
            end else begin
              Ext_DataAdr <= alignedBase;
              state       <= ADDR;
            end
          end
        end

        ADDR: begin
          // Hold the address until the memory read has settled.
          if (waitCnt == WaitLast) begin
            out_data  <= ReadData;
            out_valid <= 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
            // The checksum beat carries the last flag instead.
            out_last  <= 1'b0;
`else
            out_last  <= lastWord;
`endif
            state     <= SEND;
          end else begin
            waitCnt <= waitCnt + 2'd1;
          end
        end

        SEND: begin
          if (handshake) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
            sumReg <= sumReg + out_data;
`endif
            if (lastWord) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
              // Valid stays high: the checksum beat follows immediately.
              out_data <= sumReg + out_data;
              out_last <= 1'b1;
              state    <= CSUM;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              wordIndex   <= nextIndex;
              Ext_DataAdr <= nextAdr;
              waitCnt     <= 2'd0;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              state       <= ADDR;
            end
          end
        end

`ifdef DMEM_DUMP_CHECKSUM_EN
        CSUM: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          // cpu_hold and busy cover this cycle, then release together.
          done     <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cpu_hold  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Testbench for dmem_dump_ctrl: a memory model feeds ReadData with the
// configured latency, a monitor records every handshaken beat, and each
// scenario compares the recorded beats against a list built from the dump
// rules (aligned base + 4*i, wrapped modulo 2^32, optional trailing sum).
`timescale 1ns/1ps
module tb_dmem_dump_ctrl;

  localparam int LAT    = 1;
  localparam int RD_IDX = (LAT == 0) ? 0 : LAT - 1;
`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] adr;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] baseAdr;
  logic [15:0] wordCount;
  logic [31:0] ReadData;
  logic        outReady;
  logic [31:0] Ext_DataAdr;
  logic        cpu_hold;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  dmem_dump_ctrl #(.RD_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_adr   (baseAdr),
    .word_count (wordCount),
    .ReadData   (ReadData),
    .out_ready  (outReady),
    .Ext_DataAdr(Ext_DataAdr),
    .cpu_hold   (cpu_hold),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] memOv [logic [31:0]];

  function automatic logic [31:0] memModel(input logic [31:0] a);
    if (memOv.exists(a)) return memOv[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  logic [31:0] adrDly [0:3];
  always @(posedge clk) begin
    adrDly[0] <= Ext_DataAdr;
    for (int i = 1; i < 4; i++) adrDly[i] <= adrDly[i-1];
  end

  // Data reflects the address as it stood LAT cycles ago.
  always @(negedge clk) begin
    ReadData = memModel((LAT == 0) ? Ext_DataAdr : adrDly[RD_IDX]);
  end

  // ---------------- monitor ----------------
  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t beats[$];
  int    doneCnt = 0;
  int    doneCyc = 0;
  int    stabErr = 0;
  int    holdErr = 0;
  bit    prevStall = 1'b0;
  beat_t prevBeat;

  always @(negedge clk) begin
    beat_t b;
    b.data = out_data;
    b.adr  = Ext_DataAdr;
    b.last = out_last;
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && (!out_valid || b !== prevBeat)) stabErr++;
      if (out_valid && outReady) beats.push_back(b);
      prevStall = out_valid && !outReady;
      prevBeat  = b;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (busy !== cpu_hold || (out_valid && !busy)) holdErr++;
    end
  end

  // ---------------- reference list ----------------
  beat_t expQ[$];

  function automatic void buildExpected(input logic [31:0] base, input int count);
    logic [31:0] a;
    logic [31:0] sum;
    beat_t       b;
    expQ.delete();
    sum = 32'd0;
    a   = 32'd0;
    for (int i = 0; i < count; i++) begin
      a      = {base[31:2], 2'b00} + 32'(4 * i);
      b.data = memModel(a);
      b.adr  = a;
      b.last = (i == count - 1) && !CSUM_ON;
      sum    = sum + b.data;
      expQ.push_back(b);
    end
    if (CSUM_ON && count > 0) begin
      b.data = sum;
      b.adr  = a;
      b.last = 1'b1;
      expQ.push_back(b);
    end
  endfunction

  function automatic int expCycles(input int count);
    return count * (LAT + 2) + ((CSUM_ON && count > 0) ? 1 : 0);
  endfunction

  // ---------------- stimulus driver ----------------
  // policy 0: always ready, 1: random ready, 2: stall beat 2 for 5 cycles
  task automatic runDump(input logic [31:0] base, input logic [15:0] count,
                         input int policy, input bit pokeStart,
                         output int startIdx, output int nBeats,
                         output int doneAt, output int holdLow,
                         output bit timedOut);
    int acceptCyc;
    int doneSeen;
    int stalled;
    bit poked;
    @(posedge clk); #1;
    startIdx  = beats.size();
    stalled   = 0;
    poked     = 1'b0;
    holdLow   = 0;
    timedOut  = 1'b1;
    outReady  = 1'b1;
    start     = 1'b1;
    baseAdr   = base;
    wordCount = count;
    @(posedge clk); #1;
    acceptCyc = cyc;
    doneSeen  = doneCnt;
    start     = 1'b0;
    baseAdr   = $urandom;
    wordCount = 16'($urandom_range(1, 60000));
    for (int budget = 0; budget < 600; budget++) begin
      case (policy)
        1:       outReady = 1'($urandom_range(0, 1));
        2: begin
          if (beats.size() - startIdx == 1 && out_valid && stalled < 5) begin
            outReady = 1'b0;
            stalled++;
          end else begin
            outReady = 1'b1;
          end
        end
        default: outReady = 1'b1;
      endcase
      if (pokeStart && !poked && out_valid) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      if (!cpu_hold) holdLow++;
      if (doneCnt != doneSeen) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    outReady = 1'b1;
    nBeats   = beats.size() - startIdx;
    doneAt   = doneCyc - acceptCyc;
    $display("dump base=%h count=%0d policy=%0d beats=%0d done_after=%0d",
             base, count, policy, nBeats, doneAt);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    outReady  = 1'b1;
    baseAdr   = 32'd0;
    wordCount = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({Ext_DataAdr, out_data, cpu_hold, out_valid, out_last, busy, done} !== 69'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got adr=%h data=%h hold=%b valid=%b last=%b busy=%b done=%b want all 0",
               Ext_DataAdr, out_data, cpu_hold, out_valid, out_last, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int s, n, d, h, dc0;
    bit to;
    memOv[32'h100] = 32'h1111_1111;
    memOv[32'h104] = 32'h2222_2222;
    memOv[32'h108] = 32'h3333_3333;
    dc0 = doneCnt;
    runDump(32'h100, 16'd3, 0, 1'b0, s, n, d, h, to);
    buildExpected(32'h100, 3);
    compared++;
    if (to) begin mismatched++; $display("FAIL basic_timeout: no done within budget"); end
    compared++;
    if (n != expQ.size()) begin mismatched++; $display("FAIL basic_count: got %0d want %0d", n, expQ.size()); end
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      compared++;
      if (beats[s+i] !== expQ[i]) begin
        mismatched++;
        $display("FAIL basic_beat%0d: got data=%h adr=%h last=%b want data=%h adr=%h last=%b", i,
                 beats[s+i].data, beats[s+i].adr, beats[s+i].last, expQ[i].data, expQ[i].adr, expQ[i].last);
      end
    end
    compared++;
    if (d != expCycles(3)) begin mismatched++; $display("FAIL basic_latency: got %0d want %0d", d, expCycles(3)); end
    compared++;
    if (h != 0) begin mismatched++; $display("FAIL basic_hold: cpu_hold low for %0d cycles want 0", h); end
    repeat (4) @(posedge clk);
    compared++;
    if (doneCnt - dc0 != 1) begin mismatched++; $display("FAIL basic_done_pulses: got %0d want 1", doneCnt - dc0); end
  endtask

  task automatic test_backpressure();
    int s, n, d, h, se0;
    bit to;
    se0 = stabErr;
    runDump(32'h200, 16'd4, 2, 1'b0, s, n, d, h, to);
    buildExpected(32'h200, 4);
    compared++;
    if (to) begin mismatched++; $display("FAIL bp_timeout: no done within budget"); end
    compared++;
    if (n != expQ.size()) begin mismatched++; $display("FAIL bp_count: got %0d want %0d", n, expQ.size()); end
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      compared++;
      if (beats[s+i] !== expQ[i]) begin
        mismatched++;
        $display("FAIL bp_beat%0d: got data=%h adr=%h want data=%h adr=%h", i,
                 beats[s+i].data, beats[s+i].adr, expQ[i].data, expQ[i].adr);
      end
    end
    compared++;
    if (stabErr != se0) begin mismatched++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stabErr - se0); end
    compared++;
    if (d != expCycles(4) + 5) begin mismatched++; $display("FAIL bp_latency: got %0d want %0d", d, expCycles(4) + 5); end
  endtask

  task automatic test_zero_and_busy_start();
    int s, n, d, h;
    bit to;
    runDump(32'h300, 16'd0, 0, 1'b0, s, n, d, h, to);
    compared++;
    if (to || n != 0 || d != 0) begin
      mismatched++;
      $display("FAIL zero_count: got timeout=%0d beats=%0d done_after=%0d want 0/0/0", to, n, d);
    end
    @(posedge clk); #1;
    compared++;
    if ({cpu_hold, busy} !== 2'b00) begin mismatched++; $display("FAIL zero_hold_release: got hold=%b busy=%b want 0 0", cpu_hold, busy); end
    runDump(32'h300, 16'd3, 0, 1'b1, s, n, d, h, to);
    buildExpected(32'h300, 3);
    compared++;
    if (to || n != expQ.size()) begin mismatched++; $display("FAIL busy_start_count: got %0d want %0d", n, expQ.size()); end
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      compared++;
      if (beats[s+i] !== expQ[i]) begin
        mismatched++;
        $display("FAIL busy_start_beat%0d: got adr=%h data=%h want adr=%h data=%h", i,
                 beats[s+i].adr, beats[s+i].data, expQ[i].adr, expQ[i].data);
      end
    end
  endtask

  task automatic test_wrap();
    int s, n, d, h;
    bit to;
    runDump(32'hFFFF_FFFE, 16'd2, 0, 1'b0, s, n, d, h, to);
    compared++;
    if (to || n != 2 + int'(CSUM_ON)) begin mismatched++; $display("FAIL wrap_count: got %0d want %0d", n, 2 + int'(CSUM_ON)); end
    if (n >= 2) begin
      compared++;
      if (beats[s].adr !== 32'hFFFF_FFFC || beats[s+1].adr !== 32'h0000_0000) begin
        mismatched++;
        $display("FAIL wrap_adr: got %h,%h want fffffffc,00000000", beats[s].adr, beats[s+1].adr);
      end
      compared++;
      if (beats[s].data !== memModel(32'hFFFF_FFFC) || beats[s+1].data !== memModel(32'h0)) begin
        mismatched++;
        $display("FAIL wrap_data: got %h,%h want %h,%h", beats[s].data, beats[s+1].data,
                 memModel(32'hFFFF_FFFC), memModel(32'h0));
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, n, d, h, s0, dc0;
    bit to, hit;
    @(posedge clk); #1;
    s0        = beats.size();
    dc0       = doneCnt;
    hit       = 1'b0;
    outReady  = 1'b1;
    start     = 1'b1;
    baseAdr   = 32'h400;
    wordCount = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int budget = 0; budget < 100; budget++) begin
      if (beats.size() - s0 == 1 && out_valid) begin
        hit = 1'b1;
        break;
      end
      outReady = (beats.size() == s0);
      @(posedge clk); #1;
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL rst_mid_reach: beat 2 never presented"); end
    reset = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({Ext_DataAdr, out_data, cpu_hold, out_valid, out_last, busy, done} !== 69'd0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got adr=%h data=%h hold=%b valid=%b last=%b busy=%b done=%b want all 0",
               Ext_DataAdr, out_data, cpu_hold, out_valid, out_last, busy, done);
    end
    reset    = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (beats.size() - s0 != 1 || doneCnt != dc0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_no_resume: got beats=%0d dones=%0d busy=%b want 1/0/0",
               beats.size() - s0, doneCnt - dc0, busy);
    end
    runDump(32'h500, 16'd2, 0, 1'b0, s, n, d, h, to);
    buildExpected(32'h500, 2);
    compared++;
    if (to || n != expQ.size()) begin mismatched++; $display("FAIL rst_mid_restart_count: got %0d want %0d", n, expQ.size()); end
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      compared++;
      if (beats[s+i] !== expQ[i]) begin
        mismatched++;
        $display("FAIL rst_mid_restart_beat%0d: got adr=%h data=%h want adr=%h data=%h", i,
                 beats[s+i].adr, beats[s+i].data, expQ[i].adr, expQ[i].data);
      end
    end
  endtask

  task automatic test_checksum();
    int s, n, d, h;
    bit to;
    memOv[32'h600] = 32'hFFFF_FFFF;
    memOv[32'h604] = 32'h0000_0002;
    runDump(32'h600, 16'd2, 0, 1'b0, s, n, d, h, to);
`ifdef DMEM_DUMP_CHECKSUM_EN
    compared++;
    if (to || n != 3) begin mismatched++; $display("FAIL csum_count: got %0d want 3", n); end
    if (n == 3) begin
      compared++;
      if (beats[s+2].data !== 32'h0000_0001 || beats[s+2].last !== 1'b1) begin
        mismatched++;
        $display("FAIL csum_beat: got data=%h last=%b want 00000001 1", beats[s+2].data, beats[s+2].last);
      end
      compared++;
      if (beats[s].last !== 1'b0 || beats[s+1].last !== 1'b0) begin
        mismatched++;
        $display("FAIL csum_data_last: got %b,%b want 0,0", beats[s].last, beats[s+1].last);
      end
    end
`else
    compared++;
    if (to || n != 2) begin mismatched++; $display("FAIL nocsum_count: got %0d want 2", n); end
    if (n == 2) begin
      compared++;
      if (beats[s].last !== 1'b0 || beats[s+1].last !== 1'b1 ||
          beats[s].data !== 32'hFFFF_FFFF || beats[s+1].data !== 32'h0000_0002) begin
        mismatched++;
        $display("FAIL nocsum_beats: got %h/%b %h/%b want ffffffff/0 00000002/1",
                 beats[s].data, beats[s].last, beats[s+1].data, beats[s+1].last);
      end
    end
`endif
  endtask

  task automatic test_random();
    int s, n, d, h;
    bit to;
    logic [31:0] base;
    int cnt;
    for (int k = 0; k < 10; k++) begin
      base = $urandom;
      if (k == 3) base = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
      cnt  = (k == 5) ? 0 : $urandom_range(1, 6);
      runDump(base, 16'(cnt), 1, 1'($urandom_range(0, 1)), s, n, d, h, to);
      buildExpected(base, cnt);
      compared++;
      if (to || n != expQ.size()) begin
        mismatched++;
        $display("FAIL rand%0d_count: got %0d (timeout=%0d) want %0d", k, n, to, expQ.size());
      end
      for (int i = 0; i < n && i < expQ.size(); i++) begin
        compared++;
        if (beats[s+i] !== expQ[i]) begin
          mismatched++;
          $display("FAIL rand%0d_beat%0d: got data=%h adr=%h last=%b want data=%h adr=%h last=%b", k, i,
                   beats[s+i].data, beats[s+i].adr, beats[s+i].last, expQ[i].data, expQ[i].adr, expQ[i].last);
        end
      end
      compared++;
      if (h != 0) begin mismatched++; $display("FAIL rand%0d_hold: cpu_hold low %0d cycles want 0", k, h); end
    end
  endtask

  task automatic test_invariants();
    compared++;
    if (stabErr != 0) begin mismatched++; $display("FAIL stall_stability: got %0d violations want 0", stabErr); end
    compared++;
    if (holdErr != 0) begin mismatched++; $display("FAIL busy_hold_consistency: got %0d violations want 0", holdErr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_and_busy_start();
    test_wrap();
    test_reset_mid();
    test_checksum();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_dump_ctrl.md
# dmem_dump_ctrl

Readback engine for the data memory: the read-side counterpart of the external reset-time write path used to preload data memory. On `start` it holds the CPU in reset, sweeps a word range of data memory through the external address mux, and streams each word out over a valid/ready handshake. It is used to dump program results for checking or host upload. It sits beside the CPU top level; its `Ext_DataAdr` drives the external address input, and `cpu_hold` is ORed into the CPU reset.

## Interface
- `RD_LATENCY`, default 0: cycles from address change to valid `ReadData` (0 means combinational read). Legal range is 0..3.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- `base_adr`  input  32  byte address of the first word; bits [1:0] are ignored and forced to 0. Latched when `start` is accepted.
- `word_count`  input  16  number of words to dump. Latched when `start` is accepted.
- `ReadData`  input  32  data memory read port.
- `out_ready`  input  1  consumer accepts the current beat.
- `Ext_DataAdr`  output  32  word-aligned byte address to data memory.
- `cpu_hold`  output  1  forces the CPU into reset while the dump is active.
- `out_valid`  output  1  `out_data` holds a valid beat.
- `out_data`  output  32  dumped word (or checksum word, see Configuration).
- `out_last`  output  1  marks the final beat of the dump; qualified by `out_valid`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when the dump completes.
- The block never writes memory, and `Ext_MemWrite` must stay 0 while `busy` is high.

## Operation
- States are IDLE, ADDR, SEND and DONE.
- **IDLE**
  - `start`=1 with `word_count`≠0: latch `base_adr` (with [1:0]=0) and `word_count`, clear the index and checksum, go to ADDR.
  - `start`=1 with `word_count`=0: go directly to DONE; no beats are emitted.
- **ADDR**
  - Drive `Ext_DataAdr` = base + 4·index, computed modulo 2^32 so the address wraps from 0xFFFFFFFC to 0x00000000.
  - Stay in ADDR for RD_LATENCY+1 cycles, counted by a wait counter.
  - On the last ADDR cycle, register `ReadData` into `out_data` and go to SEND.
- **SEND**
  - `out_valid`=1. `out_data`, `out_last` and `Ext_DataAdr` are held stable until the handshake.
  - Handshake is `out_valid`&&`out_ready` at a rising edge.
  - On handshake, if index = count−1: go to DONE (or to the checksum beat when enabled). Otherwise increment the index and go to ADDR.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `cpu_hold` is still 1 in this cycle.
- `cpu_hold`=1 from the cycle after `start` is accepted through the DONE cycle inclusive. It is 0 in IDLE.
- `start` outside IDLE is ignored. Input changes after `start` is accepted have no effect until the next dump.
- `out_valid` never drops without a handshake, except on `reset`.
- **Reset**, including mid-dump: the state returns to IDLE.
  - These outputs go to 0: `out_valid`, `out_last`, `done`, `busy`, `cpu_hold`, `Ext_DataAdr`, `out_data`.
  - The in-flight beat is discarded. A dump interrupted this way does not resume.

## Timing
- If `start` is accepted at edge t:
  - ADDR occupies cycles t+1 .. t+1+RD_LATENCY.
  - The first `out_valid` is in cycle t+2+RD_LATENCY.
- If a handshake occurs in cycle h, the next `out_valid` is in cycle h+2+RD_LATENCY. There is no back-to-back streaming, so the gap is RD_LATENCY+1 cycles.
- With `out_ready` tied to 1, a dump of N words takes N·(RD_LATENCY+2)+1 cycles from acceptance to the `done` pulse.
- `word_count`=0: `done` in cycle t+1 and `cpu_hold` high for that one cycle only.
- `Ext_DataAdr` changes only on entry to ADDR.

## Configuration
- Macro: `DMEM_DUMP_CHECKSUM_EN`.
- **Defined**
  - A 32-bit running sum, modulo 2^32, accumulates each data word at its handshake.
  - After the final data handshake the FSM enters an extra state, CSUM. In CSUM, `out_valid`=1, `out_data`=sum and `out_last`=1, following the same handshake rules. After its handshake the FSM goes to DONE.
  - `out_last` is 0 on all data beats.
  - `word_count`=0 emits no checksum beat.
- **Undefined**
  - There is no CSUM state or sum register.
  - `out_last`=1 on the final data beat.

## Test plan
- **Basic dump:** preload 0x100/0x104/0x108 with 0x11111111/0x22222222/0x33333333; `start` with base=0x100, count=3, `out_ready`=1. Required: three beats in order with `Ext_DataAdr` 0x100/0x104/0x108, and `out_last` on the third beat (without the macro). `cpu_hold` is high throughout and `done` pulses once at cycle 3·(RD_LATENCY+2)+1.
- **Backpressure:** `out_ready` low for 5 cycles on beat 2. Required: `out_valid`, `out_data` and `Ext_DataAdr` are held stable, and no beat is lost or duplicated.
- **Zero count and busy start:** count=0 gives `done` the next cycle with no `out_valid`. A `start` pulsed during SEND is ignored, so the beat count stays unchanged.
- **Wrap and alignment:** base=0xFFFFFFFE, count=2. Required: addresses 0xFFFFFFFC, then 0x00000000.
- **Reset mid-dump:** assert `reset` during beat 2's SEND. Required: the next cycle has all outputs 0 and state IDLE. A following `start` dumps from the new base.
- **Checksum, macro defined:** words 0xFFFFFFFF and 0x00000002. Required: a third beat of 0x00000001 with `out_last`=1; `out_last` is 0 on both data beats.
